// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Sequencer between the pipeline MEM stage and the data-memory block RAM.
//   The RAM is dual-ported, has a 1-cycle synchronous read, and only accepts
//   whole-word writes. This block handles one access at a time:
//     - loads    : read, then extract the byte/half/word and sign/zero extend
//     - SW       : direct word write
//     - SB / SH  : read-modify-write of the containing word
//     - illegal  : misaligned or unknown funct, reported without touching RAM
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   req_i        access request, accepted when req_i && ready_o
//   we_i         1 = store, 0 = load
//   funct_i      RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i       byte address; word address is addr_i[ADDR_W+1:2]
//   w_data_i     store data, low bits used for sub-word stores
//   ready_o      controller idle
//   done_o       one-cycle completion pulse
//   err_o        valid with done_o: misaligned or illegal funct
//   read_data_o  load result, valid with done_o, held until next done_o
//   ram_en_o     RAM read enable (port B)
//   ram_we_o     RAM write enable (port A)
//   ram_addr_o   RAM word address, shared by both ports
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, valid the cycle after ram_en_o
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       w_data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       read_data_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wdata_q;     // only the sub-word store lanes are needed later
  logic              done_q;
  logic              err_q;
  logic [31:0]       read_data_q;
  logic [31:0]       ram_wdata_q;

  // Address bits above the RAM word range are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

  // ---------------------------------------------------------------------------
  // Acceptance decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic accept;
  logic funct_ok;
  logic misalign;
  logic acc_err;
  logic is_sw;

  always_comb begin
    accept   = (state_q == S_IDLE) && req_i;
    if (we_i) begin
      funct_ok = (funct_i == 3'b000) || (funct_i == 3'b001) || (funct_i == 3'b010);
    end else begin
      funct_ok = (funct_i == 3'b000) || (funct_i == 3'b001) || (funct_i == 3'b010) ||
                 (funct_i == 3'b100) || (funct_i == 3'b101);
    end
    // funct_i[1:0] gives the size for every legal code: 00 byte, 01 half, 10 word.
    misalign = ((funct_i[1:0] == 2'b01) && addr_i[0]) ||
               ((funct_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    acc_err  = !funct_ok || misalign;
    is_sw    = we_i && (funct_i == 3'b010);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (acc_err) begin
            state_d = S_DONE;
          end else if (is_sw) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:    state_d = S_RDW;
      S_RDW:   state_d = we_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the RAM word (little-endian lanes)
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = ram_rdata_i[7:0];
      2'd1:    byte_sel = ram_rdata_i[15:8];
      2'd2:    byte_sel = ram_rdata_i[23:16];
      default: byte_sel = ram_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    case (funct_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = ram_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sub-word store merge: each byte lane either keeps the old RAM byte or takes
  // the store data. A half store feeds lanes 0/2 from wdata[7:0] and lanes 1/3
  // from wdata[15:8]; a byte store feeds every lane from wdata[7:0].
  // ---------------------------------------------------------------------------
  logic [31:0] merged;
  logic        half_store;

  assign half_store = (funct_q[1:0] == 2'b01);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic lane_hit;
    logic [7:0] lane_data;
    assign lane_hit  = half_store ? (addr_q[1] == 1'(gi / 2))
                                  : (addr_q[1:0] == 2'(gi));
    assign lane_data = half_store ? wdata_q[8*(gi%2) +: 8] : wdata_q[7:0];
    assign merged[8*gi +: 8] = lane_hit ? lane_data : ram_rdata_i[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct_q     <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= 32'd0;
      ram_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      // Only the IDLE->DONE shortcut is an error; every other DONE clears it.
      err_q   <= accept && acc_err;

      if (accept) begin
        we_q    <= we_i;
        funct_q <= funct_i;
        addr_q  <= addr_i[ADDR_W+1:0];
        wdata_q <= w_data_i[15:0];
        if (acc_err) begin
          read_data_q <= 32'd0;
        end else if (is_sw) begin
          ram_wdata_q <= w_data_i;
        end
      end

      // ram_rdata_i is valid in RDW (one cycle after the RD enable).
      if (state_q == S_RDW) begin
        if (we_q) begin
          ram_wdata_q <= merged;
        end else begin
          read_data_q <= load_val;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs (never depend on the request inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_o    = (state_q == S_IDLE);
    ram_en_o   = (state_q == S_RD);
    ram_we_o   = (state_q == S_WR);
    ram_addr_o = '0;
    if ((state_q == S_RD) || (state_q == S_RDW) || (state_q == S_WR)) begin
      ram_addr_o = addr_q[ADDR_W+1:2];
    end
  end

  assign done_o      = done_q;
  assign err_o       = err_q;
  assign read_data_o = read_data_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl with a behavioural 1-cycle-read RAM.
//   Table of accesses with expected results pushed to a scoreboard queue at
//   issue and compared when done_o fires; plus hand sequences for reset state,
//   a request held while busy, and reset in the middle of a read-modify-write.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [2:0]    funct_i = 3'd0;
  logic [31:0]   addr_i = 32'd0;
  logic [31:0]   w_data_i = 32'd0;
  logic          ready_o, done_o, err_o;
  logic [31:0]   read_data_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata_i;

  dmem_ctrl #(.ADDR_W(AW)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct_i     (funct_i),
    .addr_i      (addr_i),
    .w_data_i    (w_data_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .read_data_o (read_data_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural block RAM: registered read, whole-word write.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_clr = 1'b1;
  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'd0;
      ram_rdata_i <= 32'd0;
    end else begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      if (ram_en_o) ram_rdata_i <= mem[ram_addr_o];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;
    logic        chk_mem;
    logic [31:0] mem_exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issue one access, monitor RAM strobes each cycle, compare on done.
  task automatic run_vec(input vec_t v, input int n);
    bit          ok, got;
    bit          en_s, we_s, both_s, addr_bad;
    int          lat;
    vec_t        e;
    logic [9:0]  widx;
    logic        exp_en, exp_we;
    en_s = 0; we_s = 0; both_s = 0; addr_bad = 0; got = 0; lat = 0;
    wait_ready(ok);
    if (!ok) begin
      chk("ready_timeout", 32'(ready_o), 32'd1);
      return;
    end
    req_i = 1'b1; we_i = v.we; funct_i = v.funct; addr_i = v.addr; w_data_i = v.wdata;
    sb_q.push_back(v);
    @(posedge clk_i);
    #1;
    // Scramble inputs: the controller must work from its latched copy.
    req_i = 1'b0; we_i = ~v.we; funct_i = 3'($urandom); addr_i = $urandom; w_data_i = $urandom;
    widx = v.addr[11:2];
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (ram_en_o) en_s = 1;
      if (ram_we_o) we_s = 1;
      if (ram_en_o && ram_we_o) both_s = 1;
      if ((ram_en_o || ram_we_o) && (ram_addr_o != widx)) addr_bad = 1;
      if (done_o) begin
        lat = k;
        got = 1;
        break;
      end
    end
    e = sb_q.pop_front();
    exp_en = !e.err && !(e.we && e.funct == 3'b010);
    exp_we = e.we && !e.err;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    $display("txn %0d we=%0d funct=%b addr=%h err=%0d rdata=%h lat=%0d",
             n, e.we, e.funct, e.addr, err_o, read_data_o, lat);
    chk("err", 32'(err_o), 32'(e.err));
    chk("latency", 32'(lat), 32'(e.lat));
    if (e.chk_rd) chk("read_data", read_data_o, e.rdata);
    chk("ram_en_seen", 32'(en_s), 32'(exp_en));
    chk("ram_we_seen", 32'(we_s), 32'(exp_we));
    chk("en_we_overlap", 32'(both_s), 32'd0);
    chk("ram_addr", 32'(addr_bad), 32'd0);
    if (e.chk_mem) chk("ram_word", mem[widx], e.mem_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int dones;
    bit we_seen;
    logic [31:0] rd_cap;

    //            we    funct   addr          wdata         err   chk_rd rdata         lat chk_mem mem_exp
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        2, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'b000, 32'h0000_0012, 32'hAAAAAA55, 1'b0, 1'b0, 32'h0,        4, 1'b1, 32'hDE55BEEF});
    vecs.push_back('{1'b0, 3'b010, 32'h8000_0010, 32'h0,        1'b0, 1'b1, 32'hDE55BEEF, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0016, 32'hFFFF1234, 1'b0, 1'b0, 32'h0,        4, 1'b1, 32'h12340000});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0016, 32'h0,        1'b0, 1'b1, 32'h00001234, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0014, 32'h00008001, 1'b0, 1'b0, 32'h0,        4, 1'b1, 32'h12348001});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0014, 32'h0,        1'b0, 1'b1, 32'hFFFF8001, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0014, 32'h0,        1'b0, 1'b1, 32'h00008001, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0013, 32'h0,        1'b0, 1'b1, 32'hFFFFFFDE, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0,        1'b0, 1'b1, 32'h000000DE, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0012, 32'h0,        1'b0, 1'b1, 32'h00000055, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0010, 32'h0,        1'b0, 1'b1, 32'hFFFFFFEF, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0011, 32'h0,        1'b0, 1'b1, 32'h000000BE, 3, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0011, 32'h0,        1'b1, 1'b1, 32'h0,        1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0013, 32'h0000FFFF, 1'b1, 1'b1, 32'h0,        1, 1'b1, 32'hDE55BEEF});
    vecs.push_back('{1'b0, 3'b011, 32'h0000_0010, 32'h0,        1'b1, 1'b1, 32'h0,        1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'b100, 32'h0000_0010, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        1, 1'b1, 32'hDE55BEEF});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0014, 32'h0,        1'b0, 1'b1, 32'h12348001, 3, 1'b0, 32'h0});

    // Reset state while reset is held.
    repeat (2) @(negedge clk_i);
    mem_clr = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_read_data", read_data_o, 32'd0);
    chk("rst_ram_en", 32'(ram_en_o), 32'd0);
    chk("rst_ram_we", 32'(ram_we_o), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_ram_wdata", ram_wdata_o, 32'd0);
    reset_i = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Request held high while busy must not be taken as a second access.
    wait_ready(ok);
    chk("busy_ready", 32'(ok), 32'd1);
    req_i = 1'b1; we_i = 1'b0; funct_i = 3'b010; addr_i = 32'h14;
    @(posedge clk_i);
    #1;
    we_i = 1'b1; funct_i = 3'b010; addr_i = 32'h18; w_data_i = 32'hCAFEF00D;
    dones = 0; we_seen = 0; rd_cap = 32'd0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (k == 1) chk("busy_not_ready", 32'(ready_o), 32'd0);
      if (k == 3) req_i = 1'b0;
      if (ram_we_o) we_seen = 1;
      if (done_o) begin
        dones++;
        rd_cap = read_data_o;
      end
    end
    $display("txn busy-req dones=%0d rdata=%h", dones, rd_cap);
    chk("busy_done_count", 32'(dones), 32'd1);
    chk("busy_read_data", rd_cap, 32'h12348001);
    chk("busy_no_write", 32'(we_seen), 32'd0);
    chk("busy_word6", mem[6], 32'd0);

    // Reset while an SB read-modify-write sits in RDW.
    wait_ready(ok);
    req_i = 1'b1; we_i = 1'b1; funct_i = 3'b000; addr_i = 32'h10; w_data_i = 32'h77;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(negedge clk_i);  // RD
    chk("rmw_rd_en", 32'(ram_en_o), 32'd1);
    @(negedge clk_i);  // RDW
    chk("rmw_rdw_busy", 32'(ready_o), 32'd0);
    reset_i = 1'b1;
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_ram_we", 32'(ram_we_o), 32'd0);
    dones = 0; we_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (k == 1) reset_i = 1'b0;
      if (ram_we_o) we_seen = 1;
      if (done_o) dones++;
    end
    $display("txn reset-abort dones=%0d we_seen=%0d word4=%h", dones, we_seen, mem[4]);
    chk("abort_no_write", 32'(we_seen), 32'd0);
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_word4", mem[4], 32'hDE55BEEF);

    // Controller is usable again after the abort.
    run_vec('{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDE55BEEF, 3, 1'b0, 32'h0}, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller for the data-memory block RAM (dual-port, 1-cycle synchronous read latency, whole-word writes only). It accepts one load or store at a time from the MEM stage over a req/ready handshake. Sub-word stores are done as read-modify-write, and load results are extracted and extended. Misaligned or illegal accesses are flagged without touching the RAM. It sits between the pipeline MEM stage and the RAM instance; the pipeline stalls while `ready` is low.

## Interface
- `ADDR_W`, default 10: RAM word-address width; the word address is `addr[ADDR_W+1:2]`, higher bits ignored.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: access request; accepted on an edge where `req && ready`.
- `we` in 1: 1 = store, 0 = load.
- `funct` in 3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address.
- `w_data` in 32: store data, taken from the low bits.
- `ready` out 1: controller idle, can accept a request.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misaligned or illegal funct.
- `read_data` out 32: load result, valid with `done`, held until the next `done`.
- `ram_en` out 1: RAM read enable (port B).
- `ram_we` out 1: RAM write enable (port A).
- `ram_addr` out ADDR_W: RAM word address, shared by both ports.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after `ram_en`.

## Operation
- **States:** IDLE, RD, RDW, WR, DONE. `ready` = (state == IDLE).
- **Acceptance (IDLE):** on `req`, latch `we`, `funct`, `addr`, `w_data`. Later input changes are ignored. A `req` outside IDLE is not latched; the requester holds it until accepted.
- **Legality check at acceptance:**
  - Half access with `addr[0]=1` is misaligned.
  - Word access with `addr[1:0]!=0` is misaligned.
  - Load funct 011/110/111 is illegal.
  - Store funct other than 000/001/010 is illegal.
  - Any of these goes IDLE -> DONE with `err=1` and `read_data=0`. No RAM enable is asserted.
- **Load:** IDLE -> RD -> RDW -> DONE -> IDLE.
  - RD: `ram_en=1`.
  - RDW: capture and extract from `ram_rdata` into `read_data`.
  - Byte lane is `addr[1:0]` (little-endian): byte k = bits [8k+7:8k].
  - Half lane is `addr[1]`: bits [15:0] or [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **SW:** IDLE -> WR -> DONE -> IDLE. WR: `ram_we=1`, `ram_wdata=w_data`.
- **SB/SH:** IDLE -> RD -> RDW -> WR -> DONE -> IDLE.
  - RDW captures the old word.
  - WR writes the old word with the target lane replaced by `w_data[7:0]` or `w_data[15:0]`.
- `ram_addr` is driven from the latched address in RD, RDW and WR, and is 0 in IDLE/DONE.
- `ram_en` is high only in RD. `ram_we` is high only in WR. They are never high together.
- DONE: `done=1` for exactly one cycle. `err` is valid in DONE and 0 otherwise.

## Timing
- **Reset values:** state IDLE, `ready=1`, `done=0`, `err=0`, `read_data=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, latched fields 0.
- **Latency from accept edge E to `done` high:**
  - Load: `done` high in the cycle after edge E+3.
  - SW: E+2.
  - SB/SH: E+4.
  - Error: E+1.
- `ready` returns the cycle after DONE, so back-to-back throughput is one access per (latency + 1) cycles.
- **Reset mid-operation:** immediately IDLE. A pending write is dropped: `ram_we` falls with reset, so no partial RMW write occurs. No `done` pulse is produced for the aborted access.
- **Read-after-write:** a store's WR completes before `ready` rises, so a following load sees the new data.
- All outputs except `ready`, `ram_en`, `ram_we` and `ram_addr` are registered. Those four are decoded from state and latched fields only, never from inputs.

## Test plan
- **SW then LW:** SW 0xDEADBEEF @0x10 -> RAM word 4 = 0xDEADBEEF, `done` at E+2; LW @0x10 -> `read_data`=0xDEADBEEF, `err`=0.
- **SB into word:** word 4 = 0xDEADBEEF; SB 0x55 @0x12 -> RAM word 4 = 0xDE55BEEF. `ram_en` seen in RD, `ram_we` seen in WR, `done` at E+4.
- **SH upper half and half loads:** SH 0x1234 @0x16 on word 5 = 0 -> 0x12340000. LH @0x16 -> 0x00001234. Then SH 0x8001 @0x14, LH @0x14 -> 0xFFFF8001, LHU @0x14 -> 0x00008001.
- **Byte extension:** word 4 = 0xDE55BEEF; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LB @0x12 -> 0x00000055.
- **Errors:** LW @0x11 -> `done` at E+1 with `err=1`, `read_data=0`, no `ram_en` or `ram_we`. SH @0x13 and load funct 011 -> `err=1`, RAM unchanged.
- **Reset and busy request:** assert `reset` while SB @0x10 is in RDW -> `ram_we` never asserted, word 4 unchanged, `ready=1` immediately. Also, `req` pulsed while busy -> not accepted, no extra `done`.
